// File: rtl/demo_pkg.sv
// demo_pkg: shared constants for the bus demo input front end
package demo_pkg;
    localparam int DEMO_DEBOUNCE_DEFAULT = 50000;
    localparam int DEMO_SYNC_STAGES      = 2;
    localparam int SW_D1_MODE            = 0;
    localparam int SW_D2_MODE            = 1;
    localparam int SW_D1_EN              = 2;
    localparam int SW_D2_EN              = 3;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: synchroniser chain plus stability-counter debounce for one pin
module sync_debounce
    import demo_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEMO_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEMO_DEBOUNCE_DEFAULT,
    parameter int   CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1),
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_WIDTH-1:0]   cnt;
    // any sample agreeing with the debounced value restarts qualification
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= {SYNC_STAGES{RESET_VAL}};
            dout <= RESET_VAL;
            cnt  <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            if (sync[SYNC_STAGES-1] == dout) cnt <= '0;
            else if (cnt == CNT_MAX) begin
                dout <= sync[SYNC_STAGES-1];
                cnt  <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/demo_input_conditioner.sv
// demo_input_conditioner: debounced start button and busy-gated mode/enable switches
module demo_input_conditioner
    import demo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEMO_DEBOUNCE_DEFAULT,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int SYNC_STAGES     = DEMO_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start_raw,
    input  logic [3:0] sw_raw,
    input  logic       d1_ready,
    input  logic       d2_ready,
    output logic       start_out,
    output logic       press_pulse,
    output logic       d1_mode,
    output logic       d2_mode,
    output logic       d1_en,
    output logic       d2_en
);
    logic       start_db, start_d;
    logic [3:0] sw_db, sw_q;
    sync_debounce #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH(CNT_WIDTH), .RESET_VAL(1'b1)
    ) u_start (.clk(clk), .rstn(rstn), .din(start_raw), .dout(start_db));
    for (genvar i = 0; i < 4; i++) begin : g_sw
        sync_debounce #(
            .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH(CNT_WIDTH), .RESET_VAL(1'b0)
        ) u_sw (.clk(clk), .rstn(rstn), .din(sw_raw[i]), .dout(sw_db[i]));
    end
    // switches only move while both masters are idle; they lag db by one edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_d <= 1'b1;
            sw_q    <= '0;
        end else begin
            start_d <= start_db;
            if (d1_ready & d2_ready) sw_q <= sw_db;
        end
    end
    assign start_out   = start_db;
    assign press_pulse = start_d & ~start_db;
    assign d1_mode     = sw_q[SW_D1_MODE];
    assign d2_mode     = sw_q[SW_D2_MODE];
    assign d1_en       = sw_q[SW_D1_EN];
    assign d2_en       = sw_q[SW_D2_EN];
endmodule

// File: tb/tb_demo_input_conditioner.sv
// tb_demo_input_conditioner: random and directed stimulus against a sample-window model
module tb_demo_input_conditioner;
    localparam int DB = 4;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start_raw = 1'b0;
    logic [3:0] sw_raw = 4'b0;
    logic d1_ready = 1'b1;
    logic d2_ready = 1'b1;
    logic start_out, press_pulse, d1_mode, d2_mode, d1_en, d2_en;
    int errors = 0;
    int checks = 0;
    int pulses = 0;

    demo_input_conditioner #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .start_raw(start_raw), .sw_raw(sw_raw),
        .d1_ready(d1_ready), .d2_ready(d2_ready), .start_out(start_out),
        .press_pulse(press_pulse), .d1_mode(d1_mode), .d2_mode(d2_mode),
        .d1_en(d1_en), .d2_en(d2_en)
    );

    always #5 clk = ~clk;

    // model: a channel flips when the last DB synchronised samples (raw delayed
    // by two edges) all disagree with its debounced value
    logic [4:0] mq[$] = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
    logic [4:0] m_db = 5'b00001;
    logic [4:0] m_nd;
    logic       m_pulse = 1'b0;
    logic [3:0] m_sw = 4'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
            m_db = 5'b00001;
            m_pulse = 1'b0;
            m_sw = 4'b0;
        end else begin
            m_nd = m_db;
            for (int c = 0; c < 5; c++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int k = 0; k < DB; k++) if (mq[k][c] == m_db[c]) all_diff = 1'b0;
                if (all_diff) m_nd[c] = ~m_db[c];
            end
            m_pulse = m_db[0] & ~m_nd[0];
            if (d1_ready && d2_ready) m_sw = m_db[4:1];
            m_db = m_nd;
            mq.push_back({sw_raw, start_raw});
            void'(mq.pop_front());
        end
    end

    task automatic check(string name, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_cycle", {2'b0, start_out, press_pulse, d2_en, d1_en, d2_mode, d1_mode},
              {2'b0, m_db[0], m_pulse, m_sw});
        if (press_pulse === 1'b1) pulses++;
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // counts edges from the drive point until start_out reaches target
    task automatic measure(string name, logic target, int exp);
        int got;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (got == 0 && start_out === target) got = k;
        end
        #1;
        check(name, 8'(got), 8'(exp));
    endtask

    initial begin
        int p0;
        bit seen;
        step(3);
        check("reset_start", {7'b0, start_out}, 8'd1);
        check("reset_pulse", {7'b0, press_pulse}, 8'd0);
        check("reset_sw", {4'b0, d2_en, d1_en, d2_mode, d1_mode}, 8'd0);
        p0 = pulses;
        rstn = 1'b1;
        measure("reset_release_fall", 1'b0, 6);
        check("reset_release_pulses", 8'(pulses - p0), 8'd1);

        start_raw = 1'b1;
        step(12);
        p0 = pulses;
        start_raw = 1'b0;
        measure("clean_press_fall", 1'b0, 6);
        check("clean_press_pulses", 8'(pulses - p0), 8'd1);
        p0 = pulses;
        start_raw = 1'b1;
        measure("release_rise", 1'b1, 6);
        check("release_no_pulse", 8'(pulses - p0), 8'd0);

        step(4);
        p0 = pulses;
        for (int t = 0; t < 4; t++) begin
            start_raw = (t % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        check("bounce_held", {7'b0, start_out}, 8'd1);
        start_raw = 1'b0;
        measure("bounce_settle_fall", 1'b0, 6);
        check("bounce_pulses", 8'(pulses - p0), 8'd1);
        start_raw = 1'b1;
        step(12);

        seen = 1'b0;
        sw_raw[2] = 1'b1;
        for (int t = 0; t < 14; t++) begin
            if (t == 3) sw_raw[2] = 1'b0;
            step(1);
            if (d1_en === 1'b1) seen = 1'b1;
        end
        check("glitch_d1_en", {7'b0, seen}, 8'd0);

        d1_ready = 1'b0;
        sw_raw = 4'b0101;
        step(20);
        check("busy_hold", {4'b0, d2_en, d1_en, d2_mode, d1_mode}, 8'd0);
        d1_ready = 1'b1;
        step(1);
        check("busy_release", {4'b0, d2_en, d1_en, d2_mode, d1_mode}, 8'b0101);
        sw_raw = 4'b0;
        step(12);

        p0 = pulses;
        start_raw = 1'b0;
        step(3);
        rstn = 1'b0;
        #1;
        check("async_reset_start", {7'b0, start_out}, 8'd1);
        step(2);
        check("async_reset_no_pulse", 8'(pulses - p0), 8'd0);
        rstn = 1'b1;
        measure("requalify_fall", 1'b0, 6);
        check("requalify_pulses", 8'(pulses - p0), 8'd1);

        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(5) == 0) start_raw = ~start_raw;
            for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) sw_raw[b] = ~sw_raw[b];
            d1_ready = $urandom_range(3) != 0;
            d2_ready = $urandom_range(3) != 0;
            if ($urandom_range(499) == 0) begin
                rstn = 1'b0;
                step(1);
                rstn = 1'b1;
            end
            step(1);
        end
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
